// File: rtl/noc_mem_initiator.sv
// NoC memory initiator: sends remote scratchpad write / read-request packets on
// the egress stream and collects read-response packets from the ingress stream.
module noc_mem_initiator #(
    parameter int XY_SZ   = 3,
    parameter int BW      = 32,
    parameter int BWB     = BW / 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk_ctrl,
    input  logic                 clk_ctrl_rst_high,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [2*XY_SZ-1:0]   cmd_dest,
    input  logic [31:0]          cmd_addr,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [BW-1:0]        wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [BW-1:0]        rd_data,
    output logic                 rd_last,
    output logic                 done,
    output logic                 err,
    output logic                 stream_out_TVALID,
    output logic [BW-1:0]        stream_out_TDATA,
    output logic [BWB-1:0]       stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    input  logic                 stream_out_TREADY,
    input  logic                 stream_in_TVALID,
    input  logic [BW-1:0]        stream_in_TDATA,
    input  logic [BWB-1:0]       stream_in_TKEEP,
    input  logic                 stream_in_TLAST,
    output logic                 stream_in_TREADY,
    output logic [2:0]           state_dbg
);

    // Handshakes: a beat transfers on any cycle where valid and ready are both
    // high; valid never waits on ready, and payload is held while valid && !ready.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_ADDR     = 3'd2,
        S_WDATA    = 3'd3,
        S_WAIT_RSP = 3'd4,
        S_RDATA    = 3'd5,
        S_DRAIN    = 3'd6
    } state_t;

    localparam int CNT_W = LEN_W + 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t               state, state_nxt;
    logic                 lat_write;
    logic [2*XY_SZ-1:0]   lat_dest;
    logic [31:0]          lat_addr;
    logic [LEN_W-1:0]     lat_len_m1;
    logic [CNT_W-1:0]     beat_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic                 done_set, err_set;
    logic [BW-1:0]        hdr_word, addr_word;
    logic                 hdr_ok, last_cnt, wdata_beat, rdata_beat;
    logic                 unused_keep;

    assign unused_keep = &{1'b0, stream_in_TKEEP};
    assign state_dbg   = state;
    assign last_cnt    = (beat_cnt == CNT_W'(1));
    assign wdata_beat  = wr_valid && stream_out_TREADY;
    assign rdata_beat  = stream_in_TVALID && rd_ready;

    always_comb begin
        hdr_word                        = '0;
        hdr_word[2*XY_SZ-1:0]           = lat_dest;
        hdr_word[4*XY_SZ-1:2*XY_SZ]     = HsrcId;
        hdr_word[24:16]                 = 9'(lat_len_m1);
        hdr_word[27:25]                 = lat_write ? 3'b001 : 3'b010;
        addr_word                       = '0;
        addr_word[31:0]                 = lat_addr;
    end

    // A response must come from the tile we asked, with the length we asked for.
    assign hdr_ok = (stream_in_TDATA[27:25] == 3'b011)
                 && (stream_in_TDATA[4*XY_SZ-1:2*XY_SZ] == lat_dest)
                 && (stream_in_TDATA[24:16] == 9'(lat_len_m1));

    always_ff @(posedge clk_ctrl) begin
        if (clk_ctrl_rst_high) begin
            state      <= S_IDLE;
            lat_write  <= 1'b0;
            lat_dest   <= '0;
            lat_addr   <= '0;
            lat_len_m1 <= '0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_set;
            err   <= err_set;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    lat_write  <= cmd_write;
                    lat_dest   <= cmd_dest;
                    lat_addr   <= cmd_addr;
                    lat_len_m1 <= cmd_len - LEN_W'(1);
                    // len 0 means 2^LEN_W words
                    beat_cnt   <= {(cmd_len == '0), cmd_len};
                end
                S_ADDR:     if (stream_out_TREADY) to_cnt <= '0;
                S_WDATA:    if (wdata_beat) beat_cnt <= beat_cnt - CNT_W'(1);
                S_WAIT_RSP: if (!stream_in_TVALID) to_cnt <= to_cnt + TO_W'(1);
                S_RDATA:    if (rdata_beat) beat_cnt <= beat_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = S_HDR;
            S_HDR:  if (stream_out_TREADY) state_nxt = S_ADDR;
            S_ADDR: if (stream_out_TREADY) state_nxt = lat_write ? S_WDATA : S_WAIT_RSP;
            S_WDATA: if (wdata_beat && last_cnt) begin
                done_set  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_WAIT_RSP: begin
                if (stream_in_TVALID) begin
                    if (hdr_ok) begin
                        state_nxt = S_RDATA;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = stream_in_TLAST ? S_IDLE : S_DRAIN;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RDATA: if (rdata_beat) begin
                if (last_cnt && stream_in_TLAST) begin
                    done_set  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (last_cnt) begin
                    err_set   = 1'b1;
                    state_nxt = S_DRAIN;
                end else if (stream_in_TLAST) begin
                    err_set   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: if (stream_in_TVALID && stream_in_TLAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready         = 1'b0;
        stream_out_TVALID = 1'b0;
        stream_out_TDATA  = '0;
        stream_out_TLAST  = 1'b0;
        wr_ready          = 1'b0;
        stream_in_TREADY  = 1'b0;
        rd_valid          = 1'b0;
        rd_data           = '0;
        rd_last           = 1'b0;
        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_HDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = hdr_word;
            end
            S_ADDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = addr_word;
                stream_out_TLAST  = !lat_write;
            end
            S_WDATA: begin
                stream_out_TVALID = wr_valid;
                stream_out_TDATA  = wr_data;
                stream_out_TLAST  = wr_valid && last_cnt;
                wr_ready          = stream_out_TREADY;
            end
            S_WAIT_RSP: stream_in_TREADY = 1'b1;
            S_RDATA: begin
                stream_in_TREADY = rd_ready;
                rd_valid         = stream_in_TVALID;
                rd_data          = stream_in_TDATA;
                // an early TLAST still ends the delivered burst
                rd_last          = last_cnt || stream_in_TLAST;
            end
            S_DRAIN: stream_in_TREADY = 1'b1;
            default: ;
        endcase
    end

    assign stream_out_TKEEP = {BWB{stream_out_TVALID}};

endmodule

// File: tb/tb_noc_mem_initiator.sv
// Directed bench for noc_mem_initiator: write, read, back-pressure, bad header,
// timeout, early TLAST and mid-packet reset, checked with immediate assertions.
module tb_noc_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  HsrcId;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [5:0]  cmd_dest;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, err;
    logic        o_tvalid, o_tlast, o_tready;
    logic [31:0] o_tdata;
    logic [3:0]  o_tkeep;
    logic        i_tvalid, i_tlast, i_tready;
    logic [31:0] i_tdata;
    logic [3:0]  i_tkeep;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    noc_mem_initiator #(.XY_SZ(3), .BW(32), .LEN_W(8), .TIMEOUT(16)) dut (
        .clk_ctrl(clk), .clk_ctrl_rst_high(rst), .HsrcId(HsrcId),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_dest(cmd_dest), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .stream_out_TVALID(o_tvalid), .stream_out_TDATA(o_tdata), .stream_out_TKEEP(o_tkeep),
        .stream_out_TLAST(o_tlast), .stream_out_TREADY(o_tready),
        .stream_in_TVALID(i_tvalid), .stream_in_TDATA(i_tdata), .stream_in_TKEEP(i_tkeep),
        .stream_in_TLAST(i_tlast), .stream_in_TREADY(i_tready),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [5:0] dest,
                            input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_dest  = dest;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_in(input logic v, input logic [31:0] d, input logic l);
        i_tvalid = v;
        i_tdata  = d;
        i_tlast  = l;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_tvalid"}, o_tvalid, 0);
        chk({tag, "_tdata"}, o_tdata, 0);
        chk({tag, "_tkeep"}, o_tkeep, 0);
        chk({tag, "_tlast"}, o_tlast, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_in_tready"}, i_tready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        int idx;
        logic [31:0] e;
        rst = 1'b1; HsrcId = 6'h09;
        cmd_valid = 0; cmd_write = 0; cmd_dest = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 1; o_tready = 1;
        i_tvalid = 0; i_tdata = 0; i_tlast = 0; i_tkeep = 4'hF;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // write len=4, dest {2,1}, addr 0x40
        send_cmd(1'b1, 6'h11, 32'h40, 8'd4);
        #1;
        chk("w1_hdr", o_tdata, 32'h0203_0251);
        chk("w1_hdr_last", o_tlast, 0);
        chk("w1_hdr_keep", o_tkeep, 4'hF);
        chk("w1_hdr_valid", o_tvalid, 1);
        tick();
        chk("w1_addr", o_tdata, 32'h40);
        chk("w1_addr_last", o_tlast, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hA000_0000 + i;
            #1;
            chk("w1_data", o_tdata, 32'hA000_0000 + i);
            chk("w1_data_last", o_tlast, (i == 3));
            chk("w1_wr_ready", wr_ready, 1);
            chk("w1_done_early", done, 0);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("w1_done", done, 1);
        chk("w1_err", err, 0);
        chk("w1_idle", cmd_ready, 1);
        tick();
        chk("w1_done_pulse", done, 0);

        // read len=2, addr 0x10, good response
        send_cmd(1'b0, 6'h11, 32'h10, 8'd2);
        #1;
        chk("r1_hdr", o_tdata, 32'h0401_0251);
        tick();
        chk("r1_addr", o_tdata, 32'h10);
        chk("r1_addr_last", o_tlast, 1);
        tick();
        chk("r1_wait_state", state_dbg, 4);
        drive_in(1'b1, 32'h0601_0449, 1'b0);
        #1;
        chk("r1_hdr_tready", i_tready, 1);
        tick();
        drive_in(1'b1, 32'hD000_0000, 1'b0);
        #1;
        chk("r1_d0_valid", rd_valid, 1);
        chk("r1_d0", rd_data, 32'hD000_0000);
        chk("r1_d0_last", rd_last, 0);
        tick();
        drive_in(1'b1, 32'hD000_0001, 1'b1);
        #1;
        chk("r1_d1", rd_data, 32'hD000_0001);
        chk("r1_d1_last", rd_last, 1);
        tick();
        drive_in(1'b0, 32'h0, 1'b0);
        #1;
        chk("r1_done", done, 1);
        chk("r1_err", err, 0);
        chk("r1_idle", state_dbg, 0);

        // write len=3 with egress back-pressure
        o_tready = 1'b0;
        send_cmd(1'b1, 6'h11, 32'h80, 8'd3);
        #1;
        chk("bp_hdr", o_tdata, 32'h0202_0251);
        tick();
        chk("bp_hdr_state", state_dbg, 1);
        chk("bp_hdr_held", o_tdata, 32'h0202_0251);
        o_tready = 1'b1;
        tick();
        chk("bp_addr", o_tdata, 32'h80);
        tick();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hB000_0000 + i);
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hB000_0000 + idx;
            o_tready = c[0];
            #1;
            chk("bp_wr_ready", wr_ready, o_tready);
            chk("bp_tvalid", o_tvalid, 1);
            chk("bp_done_early", done, 0);
            if (o_tready) begin
                e = exp_q.pop_front();
                chk("bp_data", o_tdata, e);
                chk("bp_last", o_tlast, (idx == 2));
                idx++;
            end else begin
                chk("bp_stall_data", o_tdata, 32'hB000_0000 + idx);
            end
            tick();
        end
        wr_valid = 1'b0;
        o_tready = 1'b1;
        #1;
        chk("bp_beats", idx, 3);
        chk("bp_done", done, 1);
        chk("bp_idle", state_dbg, 0);
        tick();

        // read len=3, response from wrong source {3,3}: drained
        send_cmd(1'b0, 6'h11, 32'h20, 8'd3);
        #1;
        chk("ws_hdr", o_tdata, 32'h0402_0251);
        tick();
        tick();
        drive_in(1'b1, 32'h0602_06C9, 1'b0);
        tick();
        chk("ws_err", err, 1);
        chk("ws_drain_state", state_dbg, 6);
        for (int w = 0; w < 3; w++) begin
            drive_in(1'b1, 32'hC000_0000 + w, (w == 2));
            #1;
            chk("ws_rd_valid", rd_valid, 0);
            chk("ws_tready", i_tready, 1);
            tick();
        end
        drive_in(1'b0, 32'h0, 1'b0);
        #1;
        chk("ws_idle", state_dbg, 0);
        chk("ws_cmd_ready", cmd_ready, 1);
        chk("ws_err_pulse", err, 0);

        // read len=1 with no response: timeout
        send_cmd(1'b0, 6'h11, 32'h30, 8'd1);
        #1;
        chk("to_hdr", o_tdata, 32'h0400_0251);
        tick();
        chk("to_addr", o_tdata, 32'h30);
        tick();
        chk("to_wait0", state_dbg, 4);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("to_wait_state", state_dbg, 4);
            chk("to_no_err", err, 0);
        end
        tick();
        chk("to_err", err, 1);
        chk("to_idle", state_dbg, 0);
        tick();
        chk("to_err_pulse", err, 0);

        // read len=3, response ends after one word
        send_cmd(1'b0, 6'h11, 32'h50, 8'd3);
        tick();
        tick();
        drive_in(1'b1, 32'h0602_0449, 1'b0);
        tick();
        chk("el_rdata_state", state_dbg, 5);
        drive_in(1'b1, 32'hE000_0000, 1'b1);
        #1;
        chk("el_rd_valid", rd_valid, 1);
        chk("el_rd_data", rd_data, 32'hE000_0000);
        chk("el_rd_last", rd_last, 1);
        tick();
        drive_in(1'b0, 32'h0, 1'b0);
        #1;
        chk("el_err", err, 1);
        chk("el_done", done, 0);
        chk("el_idle", state_dbg, 0);
        tick();

        // reset asserted during WDATA
        send_cmd(1'b1, 6'h11, 32'h60, 8'd2);
        #1;
        chk("rw_hdr", o_tdata, 32'h0201_0251);
        tick();
        tick();
        wr_valid = 1'b1;
        wr_data  = 32'hF000_0000;
        #1;
        chk("rw_wdata_state", state_dbg, 3);
        rst = 1'b1;
        tick();
        wr_valid = 1'b0;
        #1;
        check_reset_outputs("rw");
        rst = 1'b0;
        tick();
        chk("rw_stay_idle", state_dbg, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
